// File: rtl/forward_scoreboard.sv
// Operand-forwarding and load-use hazard unit: tracks in-flight destination registers
// and muxes the youngest matching stage result onto each decode read port.
module forward_scoreboard #(
  parameter int DATA_W   = 64,
  parameter int REG_AW   = 5,
  parameter int NUM_RD   = 2,
  parameter int DEPTH    = 3,
  parameter int ZERO_REG = 31,
  parameter int LOAD_LAT = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       iss_valid,
  input  logic                       iss_wr_en,
  input  logic [REG_AW-1:0]          iss_rd,
  input  logic                       iss_is_load,
  input  logic                       flush,
  input  logic [NUM_RD*REG_AW-1:0]   rs_addr,
  input  logic [NUM_RD-1:0]          rs_use,
  input  logic [NUM_RD*DATA_W-1:0]   rf_data,
  input  logic [DEPTH*DATA_W-1:0]    stg_value,
  output logic [NUM_RD*DATA_W-1:0]   op_data,
  output logic [NUM_RD-1:0]          fwd_hit,
  output logic                       stall,
  output logic [31:0]                stall_cnt
);

  localparam logic [REG_AW-1:0] ZR = REG_AW'(ZERO_REG);

  logic [DEPTH-1:0]  vld_q;
  logic [DEPTH-1:0]  ld_q;
  logic [REG_AW-1:0] rd_q [DEPTH];
  logic [31:0]       stall_cnt_q;
  logic [NUM_RD-1:0] blocked;
  logic              take;

  function automatic logic [31:0] sat_inc(input logic [31:0] c);
    return (&c) ? c : c + 32'd1;
  endfunction

  // Operand resolution: scan oldest to youngest so the youngest writer lands last
  always_comb begin
    logic [REG_AW-1:0] addr;
    logic              hit;
    logic              blk;
    logic [DATA_W-1:0] val;
    op_data = '0;
    fwd_hit = '0;
    blocked = '0;
    addr    = '0;
    hit     = 1'b0;
    blk     = 1'b0;
    val     = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      addr = rs_addr[p*REG_AW +: REG_AW];
      hit  = 1'b0;
      blk  = 1'b0;
      val  = rf_data[p*DATA_W +: DATA_W];
      for (int i = DEPTH-1; i >= 0; i--) begin
        if (rs_use[p] && vld_q[i] && (rd_q[i] == addr) && (addr != ZR)) begin
          if (ld_q[i] && (i < LOAD_LAT)) begin
            blk = 1'b1;
            hit = 1'b0;
            val = rf_data[p*DATA_W +: DATA_W];
          end else begin
            blk = 1'b0;
            hit = 1'b1;
            val = stg_value[i*DATA_W +: DATA_W];
          end
        end
      end
      if (addr == ZR) val = '0;
      op_data[p*DATA_W +: DATA_W] = val;
      fwd_hit[p] = hit;
      blocked[p] = blk;
    end
  end

  assign stall     = iss_valid & ~flush & (|blocked);
  assign take      = iss_valid & iss_wr_en & ~flush & ~stall;
  assign stall_cnt = stall_cnt_q;

  // Stage tracking: control bits reset, register tags do not
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_q       <= '0;
      stall_cnt_q <= '0;
    end else begin
      vld_q <= {vld_q[DEPTH-2:0], take};
      if (stall) stall_cnt_q <= sat_inc(stall_cnt_q);
    end
  end

  always_ff @(posedge clk) begin
    rd_q[0] <= iss_rd;
    ld_q[0] <= iss_is_load;
    for (int i = 1; i < DEPTH; i++) begin
      rd_q[i] <= rd_q[i-1];
      ld_q[i] <= ld_q[i-1];
    end
  end

endmodule

// File: tb/tb_forward_scoreboard.sv
// Directed bench for forward_scoreboard: forwarding, youngest-wins, load-use stall,
// flush priority, zero register, counter saturation and asynchronous reset.
module tb_forward_scoreboard;

  localparam logic [63:0] A  = 64'hAAAA_0000_0000_AAAA;
  localparam logic [63:0] B  = 64'hBBBB_0000_0000_BBBB;
  localparam logic [63:0] S0 = 64'h100;
  localparam logic [63:0] S1 = 64'h101;
  localparam logic [63:0] S2 = 64'h102;

  logic          clk;
  logic          reset;
  logic          iss_valid;
  logic          iss_wr_en;
  logic [4:0]    iss_rd;
  logic          iss_is_load;
  logic          flush;
  logic [9:0]    rs_addr;
  logic [1:0]    rs_use;
  logic [127:0]  rf_data;
  logic [191:0]  stg_value;
  logic [127:0]  op_data;
  logic [1:0]    fwd_hit;
  logic          stall;
  logic [31:0]   stall_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  forward_scoreboard dut (
    .clk(clk), .reset(reset), .iss_valid(iss_valid), .iss_wr_en(iss_wr_en),
    .iss_rd(iss_rd), .iss_is_load(iss_is_load), .flush(flush), .rs_addr(rs_addr),
    .rs_use(rs_use), .rf_data(rf_data), .stg_value(stg_value), .op_data(op_data),
    .fwd_hit(fwd_hit), .stall(stall), .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle();
    iss_valid   = 1'b0;
    iss_wr_en   = 1'b0;
    iss_rd      = 5'd0;
    iss_is_load = 1'b0;
    flush       = 1'b0;
    rs_use      = 2'b00;
    rs_addr     = {5'd5, 5'd3};
    rf_data     = {A, B};
    stg_value   = {S2, S1, S0};
  endtask

  task automatic issue(input logic [4:0] rd, input logic ld);
    iss_valid   = 1'b1;
    iss_wr_en   = 1'b1;
    iss_rd      = rd;
    iss_is_load = ld;
  endtask

  initial begin
    idle();
    reset = 1'b1;

    // 1: reset state
    @(negedge clk); #1;
    chk("rst_op0", op_data[63:0], B);
    chk("rst_op1", op_data[127:64], A);
    chk("rst_hit", 64'(fwd_hit), 64'd0);
    chk("rst_stall", 64'(stall), 64'd0);
    chk("rst_cnt", 64'(stall_cnt), 64'd0);
    reset = 1'b0;

    // 2: ALU forward from EX, then from WB, then retired
    @(negedge clk); idle(); issue(5'd3, 1'b0);
    @(negedge clk); idle(); rs_use = 2'b01; stg_value = {S2, S1, 64'h1234}; #1;
    chk("alu_ex_op0", op_data[63:0], 64'h1234);
    chk("alu_ex_hit", 64'(fwd_hit), 64'd1);
    chk("alu_ex_op1", op_data[127:64], A);
    @(negedge clk); idle(); rs_use = 2'b01; #1;
    chk("alu_mem_op0", op_data[63:0], S1);
    @(negedge clk); idle(); rs_use = 2'b01; stg_value = {64'h5678, S1, S0}; #1;
    chk("alu_wb_op0", op_data[63:0], 64'h5678);
    chk("alu_wb_hit", 64'(fwd_hit), 64'd1);
    @(negedge clk); idle(); rs_use = 2'b01; #1;
    chk("alu_ret_op0", op_data[63:0], B);
    chk("alu_ret_hit", 64'(fwd_hit), 64'd0);

    // 3: back-to-back writers of x7, youngest wins on both ports
    @(negedge clk); idle(); issue(5'd7, 1'b0);
    @(negedge clk); idle(); issue(5'd7, 1'b0);
    @(negedge clk); idle(); rs_use = 2'b11; rs_addr = {5'd7, 5'd7};
    stg_value = {S2, 64'h11, 64'h22}; #1;
    chk("young_op0", op_data[63:0], 64'h22);
    chk("young_op1", op_data[127:64], 64'h22);
    chk("young_hit", 64'(fwd_hit), 64'd3);
    repeat (3) begin @(negedge clk); idle(); end

    // 4: load-use stall for one cycle, then forward from MEM
    @(negedge clk); idle(); issue(5'd9, 1'b1);
    @(negedge clk); idle(); issue(5'd4, 1'b0); rs_use = 2'b01; rs_addr = {5'd5, 5'd9}; #1;
    chk("ld_stall", 64'(stall), 64'd1);
    chk("ld_blk_hit", 64'(fwd_hit), 64'd0);
    chk("ld_blk_op0", op_data[63:0], B);
    chk("ld_cnt0", 64'(stall_cnt), 64'd0);
    @(negedge clk); #1;
    chk("ld_stall_done", 64'(stall), 64'd0);
    chk("ld_fwd_op0", op_data[63:0], S1);
    chk("ld_fwd_hit", 64'(fwd_hit), 64'd1);
    chk("ld_cnt1", 64'(stall_cnt), 64'd1);
    repeat (3) begin @(negedge clk); idle(); end

    // 5: flush beats hazard; zero register never forwards
    @(negedge clk); idle(); issue(5'd9, 1'b1);
    @(negedge clk); idle(); issue(5'd4, 1'b0); flush = 1'b1;
    rs_use = 2'b01; rs_addr = {5'd5, 5'd9}; #1;
    chk("fl_stall", 64'(stall), 64'd0);
    @(negedge clk); idle(); rs_use = 2'b01; rs_addr = {5'd5, 5'd4}; #1;
    chk("fl_empty_hit", 64'(fwd_hit), 64'd0);
    chk("fl_empty_op0", op_data[63:0], B);
    chk("fl_cnt", 64'(stall_cnt), 64'd1);
    @(negedge clk); idle(); issue(5'd31, 1'b0);
    @(negedge clk); idle(); rs_use = 2'b01; rs_addr = {5'd31, 5'd31}; #1;
    chk("zr_op", op_data[63:0] | op_data[127:64], 64'd0);
    chk("zr_hit", 64'(fwd_hit), 64'd0);
    repeat (3) begin @(negedge clk); idle(); end

    // 6: counter saturation, then asynchronous reset mid-stall
    @(negedge clk); idle();
    force dut.stall_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.stall_cnt_q;
    #1;
    chk("sat_preload", 64'(stall_cnt), 64'hFFFF_FFFE);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); idle(); issue(5'd9, 1'b1);
      @(negedge clk); idle(); issue(5'd4, 1'b0); rs_use = 2'b01; rs_addr = {5'd5, 5'd9}; #1;
      chk("sat_stall", 64'(stall), 64'd1);
      @(negedge clk); idle(); #1;
      chk("sat_cnt", 64'(stall_cnt), 64'hFFFF_FFFF);
    end
    @(negedge clk); idle(); issue(5'd9, 1'b1);
    @(negedge clk); idle(); issue(5'd4, 1'b0); rs_use = 2'b01; rs_addr = {5'd5, 5'd9}; #1;
    chk("pre_rst_stall", 64'(stall), 64'd1);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_stall", 64'(stall), 64'd0);
    chk("async_rst_cnt", 64'(stall_cnt), 64'd0);
    @(negedge clk); reset = 1'b0; idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
